kara_mul_pipe: RTL and testbench

// - Parametrised, pipelined one-level Karatsuba unsigned multiplier: OUT = A*B, W-bit operands, 2W-bit product.
// - Next generation of the fixed 16-bit Karatsuba block. Adds:
//   - width parameter
//   - valid/ready handshake with backpressure
//   - tag passthrough
//   - synchronous reset
// - Used as the partial-product engine inside the modular Montgomery multiplier datapath.

---
 rtl/kara_pkg.sv | 24 ++
 rtl/kara_mul_pipe_if.sv | 27 ++
 rtl/kara_base_mul.sv | 13 +
 rtl/kara_mul_pipe.sv | 137 +++++++++++++
 tb/tb_kara_mul_pipe.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kara_pkg.sv
// Shared helpers for the pipelined Karatsuba multiplier: width math and stage count.
// Latency: n/a (package). Backpressure: n/a.
// Contents: STAGES, kara_half(), kara_p11_w(), kara_w_ok() used for the width guard in the top.
package kara_pkg;

  // Register stages from input transfer to out_valid.
  localparam int STAGES = 4;

  // Half-width of a W-bit operand.
  function automatic int kara_half(input int w);
    return w / 2;
  endfunction

  // Width of the middle product (a0+a1)*(b0+b1): two (H+1)-bit factors.
  function automatic int kara_p11_w(input int w);
    return w + 2;
  endfunction

  // The one-level split only works for even widths of at least 4 bits.
  function automatic bit kara_w_ok(input int w);
    return (w >= 4) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/kara_mul_pipe_if.sv
// Operand/product handshake bundle for kara_mul_pipe.
// Latency: n/a (wires only). Backpressure: in_ready/out_ready valid-ready pairs.
// Ports: slave = multiplier side, master = producer/consumer side.
interface kara_mul_pipe_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*W-1:0]     out_p;
  logic [TAG_W-1:0]   out_tag;

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag
  );

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag
  );
endinterface

// File: rtl/kara_base_mul.sv
// Unsigned N x N -> 2N combinational multiplier used for the three Karatsuba partial products.
// Latency: 0 cycles (purely combinational; the parent registers the result).
// Ports: i_x, i_y operands; o_p full-width product. Backpressure: none.
module kara_base_mul #(
  parameter int N = 8
) (
  input  logic [N-1:0]   i_x,
  input  logic [N-1:0]   i_y,
  output logic [2*N-1:0] o_p
);
  // Zero-extend first so the multiply is evaluated at the full product width.
  assign o_p = {{N{1'b0}}, i_x} * {{N{1'b0}}, i_y};
endmodule

// File: rtl/kara_mul_pipe.sv
// Pipelined one-level Karatsuba unsigned multiplier, out_p = a*b with tag passthrough.
// Latency: 4 cycles input transfer -> out_valid, 1 op/cycle when unstalled.
// Backpressure: global stall when out_valid && !out_ready; every stage holds, in_ready = !stall.
// Ports: clk, rst (sync, active-high), bus = kara_mul_pipe_if.slave (a/b/in_tag in, out_p/out_tag out).
module kara_mul_pipe
  import kara_pkg::*;
#(
  parameter int W     = 16,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  kara_mul_pipe_if.slave  bus
);

  localparam int H     = kara_half(W);
  localparam int P11_W = kara_p11_w(W);

  if (!kara_w_ok(W)) begin : g_bad_width
    $fatal(1, "kara_mul_pipe: W must be even and >= 4");
  end

  logic               w_stall;

  // S1: operand capture
  logic               r_s1_vld;
  logic [W-1:0]       r_s1_a;
  logic [W-1:0]       r_s1_b;
  logic [TAG_W-1:0]   r_s1_tag;

  // S2: halves and half-sums
  logic               r_s2_vld;
  logic [H-1:0]       r_s2_a0, r_s2_a1, r_s2_b0, r_s2_b1;
  logic [H:0]         r_s2_sa, r_s2_sb;
  logic [TAG_W-1:0]   r_s2_tag;

  // S3: partial products
  logic [2*H-1:0]     w_p0, w_p2;
  logic [P11_W-1:0]   w_p11;
  logic               r_s3_vld;
  logic [2*H-1:0]     r_s3_p0, r_s3_p2;
  logic [P11_W-1:0]   r_s3_p11;
  logic [TAG_W-1:0]   r_s3_tag;

  // S4: recombination
  logic [P11_W-1:0]   w_p1;
  logic [2*W-1:0]     w_sum;
  logic               r_s4_vld;
  logic [2*W-1:0]     r_s4_p;
  logic [TAG_W-1:0]   r_s4_tag;

  // Only the output stage can be blocked, so a single stall freezes the whole pipe.
  assign w_stall      = r_s4_vld && !bus.out_ready;
  assign bus.in_ready = !w_stall;

  assign bus.out_valid = r_s4_vld;
  assign bus.out_p     = r_s4_p;
  assign bus.out_tag   = r_s4_tag;

  kara_base_mul #(.N(H)) u_mul_p0 (
    .i_x (r_s2_a0),
    .i_y (r_s2_b0),
    .o_p (w_p0)
  );

  kara_base_mul #(.N(H)) u_mul_p2 (
    .i_x (r_s2_a1),
    .i_y (r_s2_b1),
    .o_p (w_p2)
  );

  // Half-sums carry one extra bit, so the middle product is (H+1) x (H+1).
  kara_base_mul #(.N(H + 1)) u_mul_p11 (
    .i_x (r_s2_sa),
    .i_y (r_s2_sb),
    .o_p (w_p11)
  );

  // Middle term a0*b1 + a1*b0; never negative and fits in 2H+1 bits.
  assign w_p1 = r_s3_p11 - {2'b00, r_s3_p0} - {2'b00, r_s3_p2};

  // Every term is widened to 2W before the sum so no carry is lost.
  assign w_sum = {{W{1'b0}}, r_s3_p0}
               + ({{(W-2){1'b0}}, w_p1} << H)
               + {r_s3_p2, {W{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_tag <= '0;
      r_s2_vld <= 1'b0;
      r_s2_a0  <= '0;
      r_s2_a1  <= '0;
      r_s2_b0  <= '0;
      r_s2_b1  <= '0;
      r_s2_sa  <= '0;
      r_s2_sb  <= '0;
      r_s2_tag <= '0;
      r_s3_vld <= 1'b0;
      r_s3_p0  <= '0;
      r_s3_p2  <= '0;
      r_s3_p11 <= '0;
      r_s3_tag <= '0;
      r_s4_vld <= 1'b0;
      r_s4_p   <= '0;
      r_s4_tag <= '0;
    end else if (!w_stall) begin
      // in_valid while unstalled is exactly an input transfer; a bubble loads valid=0.
      r_s1_vld <= bus.in_valid;
      r_s1_a   <= bus.a;
      r_s1_b   <= bus.b;
      r_s1_tag <= bus.in_tag;

      r_s2_vld <= r_s1_vld;
      r_s2_a0  <= r_s1_a[H-1:0];
      r_s2_a1  <= r_s1_a[W-1:H];
      r_s2_b0  <= r_s1_b[H-1:0];
      r_s2_b1  <= r_s1_b[W-1:H];
      r_s2_sa  <= {1'b0, r_s1_a[H-1:0]} + {1'b0, r_s1_a[W-1:H]};
      r_s2_sb  <= {1'b0, r_s1_b[H-1:0]} + {1'b0, r_s1_b[W-1:H]};
      r_s2_tag <= r_s1_tag;

      r_s3_vld <= r_s2_vld;
      r_s3_p0  <= w_p0;
      r_s3_p2  <= w_p2;
      r_s3_p11 <= w_p11;
      r_s3_tag <= r_s2_tag;

      r_s4_vld <= r_s3_vld;
      r_s4_p   <= w_sum;
      r_s4_tag <= r_s3_tag;
    end
  end

endmodule

// File: tb/tb_kara_mul_pipe.sv
// Self-checking bench for kara_mul_pipe at W=16 (directed + random) and W=32 / W=8 (corners + random).
// Expected products come from plain a*b arithmetic on 64-bit values; tags from an in-order scoreboard.
// Prints one CHECKS/ERRORS summary line, then finishes.
module tb_kara_mul_pipe;

  localparam int NRAND = 10000;
  localparam int MAXC  = 40000;

  logic clk;
  logic rst;

  int checks;
  int errors;

  kara_mul_pipe_if #(.W(16), .TAG_W(4)) if16 ();
  kara_mul_pipe_if #(.W(32), .TAG_W(4)) if32 ();
  kara_mul_pipe_if #(.W(8),  .TAG_W(4)) if8 ();

  kara_mul_pipe #(.W(16), .TAG_W(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
  kara_mul_pipe #(.W(32), .TAG_W(4)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
  kara_mul_pipe #(.W(8),  .TAG_W(4)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [31:0] p;
  } vec_t;

  vec_t vt[6];

  // Per-build random stimulus, observed outputs and a ring scoreboard of {tag, product}.
  logic        iv[3];
  logic        orr[3];
  logic [63:0] ra[3];
  logic [63:0] rb[3];
  logic [3:0]  rt[3];
  logic        ir[3];
  logic        ov[3];
  logic [63:0] op[3];
  logic [3:0]  ot[3];
  logic [67:0] sb[3][8];
  int          wr[3];
  int          rd[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mask_of(input int k);
    case (k)
      0:       return 64'h0000_0000_0000_FFFF;
      1:       return 64'h0000_0000_FFFF_FFFF;
      default: return 64'h0000_0000_0000_00FF;
    endcase
  endfunction

  task automatic drive_all();
    if16.in_valid = iv[0]; if16.a = ra[0][15:0]; if16.b = rb[0][15:0];
    if16.in_tag = rt[0];   if16.out_ready = orr[0];
    if32.in_valid = iv[1]; if32.a = ra[1][31:0]; if32.b = rb[1][31:0];
    if32.in_tag = rt[1];   if32.out_ready = orr[1];
    if8.in_valid = iv[2];  if8.a = ra[2][7:0];   if8.b = rb[2][7:0];
    if8.in_tag = rt[2];    if8.out_ready = orr[2];
  endtask

  task automatic sample_all();
    ir[0] = if16.in_ready; ov[0] = if16.out_valid; op[0] = 64'(if16.out_p); ot[0] = if16.out_tag;
    ir[1] = if32.in_ready; ov[1] = if32.out_valid; op[1] = 64'(if32.out_p); ot[1] = if32.out_tag;
    ir[2] = if8.in_ready;  ov[2] = if8.out_valid;  op[2] = 64'(if8.out_p);  ot[2] = if8.out_tag;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bp_a[6];
    logic [15:0] bp_b[6];
    logic [15:0] ra16[3];
    logic [15:0] rb16[3];
    logic [31:0] prev_p;
    logic [3:0]  prev_tag;
    logic        prev_st;
    logic        st;
    int          idx;
    int          got;
    int          tot_rd;
    bit          fin;

    vt[0] = '{16'h1234, 16'h5678, 4'h1, 32'h0626_0060};
    vt[1] = '{16'h0000, 16'hABCD, 4'h2, 32'h0000_0000};
    vt[2] = '{16'h0100, 16'h0100, 4'h3, 32'h0001_0000};
    vt[3] = '{16'hFFFF, 16'h0001, 4'h4, 32'h0000_FFFF};
    vt[4] = '{16'h8000, 16'h8000, 4'h5, 32'h4000_0000};
    vt[5] = '{16'h00FF, 16'hFF00, 4'h6, 32'h00FE_0100};

    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b1; ra[k] = '0; rb[k] = '0; rt[k] = '0;
      wr[k] = 0; rd[k] = 0;
    end
    drive_all();

    // Reset held 3 cycles with a valid operand presented: nothing may be captured or shown.
    rst = 1'b1;
    iv[0] = 1'b1; ra[0] = 64'h1234; rb[0] = 64'h4321; rt[0] = 4'h7;
    drive_all();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_valid", 64'(if16.out_valid), 64'd0);
      chk("rst_out_p",     64'(if16.out_p),     64'd0);
      chk("rst_out_tag",   64'(if16.out_tag),   64'd0);
    end
    rst = 1'b0;
    iv[0] = 1'b0;
    drive_all();
    #1;
    chk("rst_in_ready", 64'(if16.in_ready), 64'd1);

    // Single all-ones op per build; result exactly 4 cycles after the transfer.
    iv[0] = 1'b1; ra[0] = 64'hFFFF;      rb[0] = 64'hFFFF;      rt[0] = 4'h5;
    iv[1] = 1'b1; ra[1] = 64'hFFFF_FFFF; rb[1] = 64'hFFFF_FFFF; rt[1] = 4'h3;
    iv[2] = 1'b1; ra[2] = 64'hFF;        rb[2] = 64'h01;        rt[2] = 4'h9;
    drive_all();
    step();
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    drive_all();
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      if (j < 3) begin
        chk("corner16_early", 64'(if16.out_valid), 64'd0);
        chk("corner32_early", 64'(if32.out_valid), 64'd0);
      end else begin
        chk("corner16_valid", 64'(if16.out_valid), 64'd1);
        chk("corner16_p",     64'(if16.out_p),     64'hFFFE_0001);
        chk("corner16_tag",   64'(if16.out_tag),   64'h5);
        chk("corner32_valid", 64'(if32.out_valid), 64'd1);
        chk("corner32_p",     64'(if32.out_p),     64'hFFFF_FFFE_0000_0001);
        chk("corner32_tag",   64'(if32.out_tag),   64'h3);
        chk("corner8_valid",  64'(if8.out_valid),  64'd1);
        chk("corner8_p",      64'(if8.out_p),      64'h00FF);
        chk("corner8_tag",    64'(if8.out_tag),    64'h9);
      end
    end
    step();

    // Table vectors streamed back-to-back; output t reflects the vector issued 3 loop steps earlier.
    for (int t = 0; t < 6 + 4; t++) begin
      if (t < 6) begin
        if16.in_valid = 1'b1; if16.a = vt[t].a; if16.b = vt[t].b; if16.in_tag = vt[t].tag;
      end else begin
        if16.in_valid = 1'b0;
      end
      step();
      if ((t - 3) >= 0 && (t - 3) < 6) begin
        chk("stream_valid", 64'(if16.out_valid), 64'd1);
        chk("stream_p",     64'(if16.out_p),     64'(vt[t-3].p));
        chk("stream_tag",   64'(if16.out_tag),   64'(vt[t-3].tag));
      end else begin
        chk("stream_idle", 64'(if16.out_valid), 64'd0);
      end
    end

    // Backpressure: 6 ops, out_ready low for 5 cycles while the pipe is full.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    idx = 0; got = 0; prev_st = 1'b0; prev_p = '0; prev_tag = '0;
    for (int c = 0; c < 30; c++) begin
      if16.in_valid  = (idx < 6);
      if16.a         = bp_a[idx % 6];
      if16.b         = bp_b[idx % 6];
      if16.in_tag    = 4'(idx);
      if16.out_ready = !(c >= 4 && c < 9);
      #1;
      st = if16.out_valid && !if16.out_ready;
      if (st) chk("bp_in_ready", 64'(if16.in_ready), 64'd0);
      if (st && prev_st) begin
        chk("bp_hold_p",   64'(if16.out_p),   64'(prev_p));
        chk("bp_hold_tag", 64'(if16.out_tag), 64'(prev_tag));
      end
      if (if16.out_valid && if16.out_ready) begin
        if (got < 6) begin
          chk("bp_tag", 64'(if16.out_tag), 64'(got));
          chk("bp_p",   64'(if16.out_p),   64'(bp_a[got]) * 64'(bp_b[got]));
        end else begin
          chk("bp_extra_output", 64'd1, 64'(got < 6));
        end
        got++;
      end
      if (if16.in_valid && if16.in_ready) idx++;
      prev_st = st; prev_p = if16.out_p; prev_tag = if16.out_tag;
      step();
    end
    chk("bp_count", 64'(got), 64'd6);

    // Reset mid-flight: three ops dropped, a later op returns at latency 4.
    for (int i = 0; i < 3; i++) begin
      ra16[i] = 16'($urandom);
      rb16[i] = 16'($urandom);
    end
    if16.out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if16.in_valid = (c < 3) || (c == 6);
      if16.a        = (c < 3) ? ra16[c] : 16'hBEEF;
      if16.b        = (c < 3) ? rb16[c] : 16'h0123;
      if16.in_tag   = (c < 3) ? 4'(c + 8) : 4'hC;
      rst           = (c == 3);
      #1;
      if (c == 10) begin
        chk("rstmid_valid", 64'(if16.out_valid), 64'd1);
        chk("rstmid_p",     64'(if16.out_p),     64'hBEEF * 64'h0123);
        chk("rstmid_tag",   64'(if16.out_tag),   64'hC);
      end else begin
        chk("rstmid_quiet", 64'(if16.out_valid), 64'd0);
      end
      step();
    end
    rst = 1'b0;
    if16.in_valid = 1'b0;

    // Random traffic on all three builds with random in_valid/out_ready.
    for (int k = 0; k < 3; k++) begin
      wr[k] = 0; rd[k] = 0;
    end
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      fin = 1'b1;
      for (int k = 0; k < 3; k++) if (wr[k] < NRAND || rd[k] != wr[k]) fin = 1'b0;
      if (fin) break;
      for (int k = 0; k < 3; k++) begin
        iv[k]  = (wr[k] < NRAND) && ($urandom_range(0, 3) != 0);
        orr[k] = (wr[k] >= NRAND) || ($urandom_range(0, 3) != 0);
        ra[k]  = ($urandom_range(0, 15) == 0) ? mask_of(k) : ({$urandom, $urandom} & mask_of(k));
        rb[k]  = ($urandom_range(0, 15) == 0) ? mask_of(k) : ({$urandom, $urandom} & mask_of(k));
        rt[k]  = 4'($urandom_range(0, 15));
      end
      drive_all();
      #1;
      sample_all();
      for (int k = 0; k < 3; k++) begin
        if (cyc < 2000) chk("rnd_in_ready", 64'(ir[k]), 64'(!(ov[k] && !orr[k])));
        if (ov[k] && orr[k]) begin
          if (rd[k] == wr[k]) begin
            chk("rnd_spurious", 64'(ov[k]), 64'd0);
          end else begin
            chk("rnd_p",   op[k],       sb[k][rd[k] % 8][63:0]);
            chk("rnd_tag", 64'(ot[k]), 64'(sb[k][rd[k] % 8][67:64]));
            rd[k]++;
          end
        end
        if (iv[k] && ir[k]) begin
          sb[k][wr[k] % 8] = {rt[k], ra[k] * rb[k]};
          wr[k]++;
        end
      end
      step();
    end
    tot_rd = rd[0] + rd[1] + rd[2];
    chk("rnd_drained", 64'(tot_rd), 64'(3 * NRAND));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
